// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one registered result broadcast bus (CDB) between the
// ALU, LSU and MUL writeback ports.
//
// Each unit's {rob_idx, value} is queued in a DEPTH-entry FIFO. Every cycle,
// one non-empty FIFO is selected round-robin, starting after the last winner.
// Its head is popped into the CDB register.
//
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i (sync discard)
//   <unit>_wb_valid_i / _rob_idx_i / _value_i : writeback push from a unit
//   <unit>_wb_ready_o                         : unit FIFO can accept (count only)
//   cdb_valid_o / cdb_rob_idx_o / cdb_value_o : registered broadcast
//   cdb_src_o                                 : 0 ALU, 1 LSU, 2 MUL
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              alu_wb_valid_i,
  input  logic [TAG_W-1:0]  alu_wb_rob_idx_i,
  input  logic [DATA_W-1:0] alu_wb_value_i,
  output logic              alu_wb_ready_o,
  input  logic              lsu_wb_valid_i,
  input  logic [TAG_W-1:0]  lsu_wb_rob_idx_i,
  input  logic [DATA_W-1:0] lsu_wb_value_i,
  output logic              lsu_wb_ready_o,
  input  logic              mul_wb_valid_i,
  input  logic [TAG_W-1:0]  mul_wb_rob_idx_i,
  input  logic [DATA_W-1:0] mul_wb_value_i,
  output logic              mul_wb_ready_o,
  output logic              cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_rob_idx_o,
  output logic [DATA_W-1:0] cdb_value_o,
  output logic [1:0]        cdb_src_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [1:0] SRC_MUL = 2'd2;

  logic [2:0]       in_valid;
  logic [ENT_W-1:0] in_data [3];

  logic [ENT_W-1:0] mem   [3][DEPTH];
  logic [PTR_W-1:0] head  [3];
  logic [PTR_W-1:0] tail  [3];
  logic [CNT_W-1:0] count [3];

  logic [2:0] ready;
  logic [2:0] nonempty;
  logic [2:0] push;
  logic [2:0] pop;

  logic [1:0] last_grant;
  logic [1:0] grant;
  logic [1:0] cand;
  logic       grant_vld;

  // (g + k) mod 3 for g in 0..2, k in 1..3
  function automatic logic [1:0] rr_next(input logic [1:0] g, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, g} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign in_valid   = {mul_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};
  assign in_data[0] = {alu_wb_rob_idx_i, alu_wb_value_i};
  assign in_data[1] = {lsu_wb_rob_idx_i, lsu_wb_value_i};
  assign in_data[2] = {mul_wb_rob_idx_i, mul_wb_value_i};

  // Ready depends on registered count only: a full FIFO stays not-ready even
  // if it is popped this cycle, which keeps the unit-side path short.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int u = 0; u < 3; u++) begin
      ready[u]    = (count[u] != FULL) && !flush_i && !reset_i;
      nonempty[u] = (count[u] != '0);
      push[u]     = in_valid[u] && ready[u];
    end
  end

  assign alu_wb_ready_o = ready[0];
  assign lsu_wb_ready_o = ready[1];
  assign mul_wb_ready_o = ready[2];

  // Round-robin search: walk k = 3 down to 1 so the smallest offset after
  // last_grant that is non-empty is the final assignment and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = last_grant;
    cand      = last_grant;
    for (int k = 3; k >= 1; k--) begin
      cand = rr_next(last_grant, 2'(k));
      if (nonempty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  // A flush discards everything, so nothing is popped into the CDB.
  always_comb begin
    pop = '0;
    if (grant_vld && !flush_i) pop[grant] = 1'b1;
  end

  // ---- stage p0: FIFO storage and pointers ----
  always_ff @(posedge clk_i) begin
    for (int u = 0; u < 3; u++) begin
      if (push[u]) mem[u][tail[u]] <= in_data[u];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int u = 0; u < 3; u++) begin
        head[u]  <= '0;
        tail[u]  <= '0;
        count[u] <= '0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        if (push[u]) tail[u] <= tail[u] + 1'b1;
        if (pop[u])  head[u] <= head[u] + 1'b1;
        case ({push[u], pop[u]})
          2'b10:   count[u] <= count[u] + 1'b1;
          2'b01:   count[u] <= count[u] - 1'b1;
          default: count[u] <= count[u];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) last_grant <= SRC_MUL;
    else if (grant_vld && !flush_i) last_grant <= grant;
  end

  // ---- stage p1: registered CDB ----
  // Index/value/src hold on idle cycles; only valid drops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdb_valid_o   <= 1'b0;
      cdb_rob_idx_o <= '0;
      cdb_value_o   <= '0;
      cdb_src_o     <= '0;
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
    end else if (grant_vld) begin
      cdb_valid_o                  <= 1'b1;
      {cdb_rob_idx_o, cdb_value_o} <= mem[grant][head[grant]];
      cdb_src_o                    <= grant;
    end else begin
      cdb_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single push, concurrent push order,
// fairness after an LSU grant, streaming back-pressure, flush, mid-run reset.
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset_i, flush_i;
  logic              alu_v, lsu_v, mul_v;
  logic [TAG_W-1:0]  alu_idx, lsu_idx, mul_idx;
  logic [DATA_W-1:0] alu_val, lsu_val, mul_val;
  logic              alu_rdy, lsu_rdy, mul_rdy;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_idx;
  logic [DATA_W-1:0] cdb_value;
  logic [1:0]        cdb_src;
  logic [2:0]        rdy;

  int checks = 0;
  int errors = 0;

  int seq      [3];
  int exp_next [3];
  int bcount   [3];
  int prev_src;
  bit lsu_dropped;

  always #5 clk = ~clk;
  assign rdy = {mul_rdy, lsu_rdy, alu_rdy};

  wb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .alu_wb_valid_i(alu_v), .alu_wb_rob_idx_i(alu_idx), .alu_wb_value_i(alu_val),
    .alu_wb_ready_o(alu_rdy),
    .lsu_wb_valid_i(lsu_v), .lsu_wb_rob_idx_i(lsu_idx), .lsu_wb_value_i(lsu_val),
    .lsu_wb_ready_o(lsu_rdy),
    .mul_wb_valid_i(mul_v), .mul_wb_rob_idx_i(mul_idx), .mul_wb_value_i(mul_val),
    .mul_wb_ready_o(mul_rdy),
    .cdb_valid_o(cdb_valid), .cdb_rob_idx_o(cdb_idx), .cdb_value_o(cdb_value),
    .cdb_src_o(cdb_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic v, input logic [TAG_W-1:0] idx,
                       input logic [DATA_W-1:0] val);
    case (u)
      0:       begin alu_v = v; alu_idx = idx; alu_val = val; end
      1:       begin lsu_v = v; lsu_idx = idx; lsu_val = val; end
      default: begin mul_v = v; mul_idx = idx; mul_val = val; end
    endcase
  endtask

  task automatic idle;
    alu_v = 1'b0; lsu_v = 1'b0; mul_v = 1'b0;
  endtask

  task automatic expect_cdb(input string tag, input logic [TAG_W-1:0] idx,
                            input logic [DATA_W-1:0] val, input logic [1:0] src);
    check({tag, "_valid"}, 64'(cdb_valid), 64'(1'b1));
    check({tag, "_idx"},   64'(cdb_idx),   64'(idx));
    check({tag, "_value"}, 64'(cdb_value), 64'(val));
    check({tag, "_src"},   64'(cdb_src),   64'(src));
  endtask

  // Scoreboard for the streaming phase: per-source in-order values and
  // strict rotation while every FIFO stays occupied.
  task automatic observe(input bit rot_check);
    int s;
    if (cdb_valid) begin
      s = int'(cdb_src);
      if (s > 2) begin
        check("bp_src_range", 64'(s), 64'(0));
      end else begin
        check("bp_value", 64'(cdb_value), 64'(32'(s * 256 + exp_next[s])));
        check("bp_idx",   64'(cdb_idx),   64'(5'(exp_next[s])));
        exp_next[s]++;
        bcount[s]++;
        if (rot_check && prev_src >= 0)
          check("bp_rotate", 64'(s), 64'((prev_src + 1) % 3));
        prev_src = s;
      end
    end
  endtask

  task automatic fill_all(input int base);
    for (int c = 0; c < 3; c++) begin
      for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(base + u), 32'(base + u));
      tick();
    end
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0;
    alu_idx = '0; lsu_idx = '0; mul_idx = '0;
    alu_val = '0; lsu_val = '0; mul_val = '0;
    idle();

    // Reset state
    tick(); tick();
    check("rst_ready", 64'(rdy), 64'(3'b000));
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_idx",   64'(cdb_idx),   64'(0));
    check("rst_value", 64'(cdb_value), 64'(0));
    check("rst_src",   64'(cdb_src),   64'(0));
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(rdy), 64'(3'b111));

    // Single ALU push: broadcast two edges later for one cycle
    drive(0, 1'b1, 5'd3, 32'h11);
    tick();
    idle();
    check("single_lat", 64'(cdb_valid), 64'(0));
    tick();
    expect_cdb("single", 5'd3, 32'h11, 2'd0);
    tick();
    check("single_once", 64'(cdb_valid), 64'(0));

    // Concurrent push right after reset: order ALU, LSU, MUL
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    drive(0, 1'b1, 5'd1, 32'hA);
    drive(1, 1'b1, 5'd2, 32'hB);
    drive(2, 1'b1, 5'd4, 32'hC);
    tick();
    idle();
    tick(); expect_cdb("conc0", 5'd1, 32'hA, 2'd0);
    tick(); expect_cdb("conc1", 5'd2, 32'hB, 2'd1);
    tick(); expect_cdb("conc2", 5'd4, 32'hC, 2'd2);
    tick();
    check("conc_end_valid", 64'(cdb_valid), 64'(0));
    check("conc_hold_idx",  64'(cdb_idx),   64'(4));
    check("conc_hold_src",  64'(cdb_src),   64'(2));

    // Fairness: make LSU the last grant, then ALU+MUL together -> MUL first
    drive(1, 1'b1, 5'd9, 32'h99);
    tick(); idle();
    tick(); expect_cdb("fair_lsu", 5'd9, 32'h99, 2'd1);
    tick();
    drive(0, 1'b1, 5'd5, 32'h55);
    drive(2, 1'b1, 5'd6, 32'h66);
    tick(); idle();
    tick(); expect_cdb("fair_mul", 5'd6, 32'h66, 2'd2);
    tick(); expect_cdb("fair_alu", 5'd5, 32'h55, 2'd0);
    tick();
    check("fair_end", 64'(cdb_valid), 64'(0));

    // Streaming back-pressure: all three hold valid every cycle
    for (int u = 0; u < 3; u++) begin seq[u] = 0; exp_next[u] = 0; bcount[u] = 0; end
    prev_src = -1;
    lsu_dropped = 1'b0;
    for (int c = 0; c < 15; c++) begin
      logic [2:0] acc;
      for (int u = 0; u < 3; u++) drive(u, 1'b1, 5'(seq[u]), 32'(u * 256 + seq[u]));
      #1;
      acc = rdy;
      if (!lsu_rdy) lsu_dropped = 1'b1;
      tick();
      for (int u = 0; u < 3; u++) if (acc[u]) seq[u]++;
      observe(1'b1);
    end
    idle();
    for (int c = 0; c < 10; c++) begin
      tick();
      observe(1'b0);
    end
    check("bp_lsu_dropped", 64'(lsu_dropped), 64'(1));
    for (int u = 0; u < 3; u++) check("bp_count", 64'(bcount[u]), 64'(seq[u]));
    check("bp_drained", 64'(cdb_valid), 64'(0));

    // Flush with FIFOs loaded
    fill_all(16);
    flush_i = 1'b1;
    #1;
    check("flush_ready_low", 64'(rdy), 64'(3'b000));
    tick();
    flush_i = 1'b0;
    idle();
    check("flush_valid", 64'(cdb_valid), 64'(0));
    #1;
    check("flush_ready", 64'(rdy), 64'(3'b111));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("flush_no_old", 64'(cdb_valid), 64'(0));
    end

    // Reset mid-operation, then a fresh ALU push
    fill_all(20);
    reset_i = 1'b1;
    #1;
    check("mrst_ready_low", 64'(rdy), 64'(3'b000));
    tick();
    reset_i = 1'b0;
    idle();
    check("mrst_valid", 64'(cdb_valid), 64'(0));
    check("mrst_idx",   64'(cdb_idx),   64'(0));
    check("mrst_value", 64'(cdb_value), 64'(0));
    check("mrst_src",   64'(cdb_src),   64'(0));
    drive(0, 1'b1, 5'd7, 32'h77);
    #1;
    check("mrst_ready", 64'(rdy), 64'(3'b111));
    tick();
    idle();
    check("mrst_lat", 64'(cdb_valid), 64'(0));
    tick();
    expect_cdb("mrst_push", 5'd7, 32'h77, 2'd0);
    tick();
    check("mrst_once", 64'(cdb_valid), 64'(0));
    tick();
    check("mrst_quiet", 64'(cdb_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
